// File: rtl/seg_display_scan.sv
// rtl/seg_display_scan.sv - time-multiplexed 4-digit common-anode seven-segment scan driver
// Optional display flashing is compiled in when the macro SEG_BLINK_EN is defined.
module seg_display_scan #(
    parameter int DIV          = 100000,
    parameter int BLANK        = 1000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            blink,
    input  logic [3:0][6:0] digits,
    output logic [3:0]      an,
    output logic [6:0]      seg,
    output logic            dp
);

    localparam int            CW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);

    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_idx;
    logic [3:0][6:0] r_shadow;
    logic [3:0]      r_an;
    logic [6:0]      r_seg;

    logic            w_slot_end;
    logic            w_frame_end;
    logic            w_suppress;
    logic            w_dark;
    logic [3:0]      w_an_next;
    logic [6:0]      w_seg_next;

    assign w_slot_end  = (r_cnt == CNT_LAST);
    assign w_frame_end = w_slot_end && (r_idx == 2'd3);

`ifdef SEG_BLINK_EN
    localparam int            FW          = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0] FRAMES_LAST = FW'(BLINK_FRAMES - 1);

    logic [FW-1:0] r_frames;
    logic          r_phase;

    // Count completed frames; the blink phase flips every BLINK_FRAMES frames regardless of blink
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frames <= '0;
            r_phase  <= 1'b0;
        end else if (!en) begin
            r_frames <= '0;
            r_phase  <= 1'b0;
        end else if (w_frame_end) begin
            if (r_frames == FRAMES_LAST) begin
                r_frames <= '0;
                r_phase  <= ~r_phase;
            end else begin
                r_frames <= r_frames + FW'(1);
            end
        end
    end

    assign w_suppress = blink && r_phase;
`else
    logic w_unused_blink;

    assign w_unused_blink = blink;
    assign w_suppress     = 1'b0;
`endif

    // Slot prescaler and digit index; disabling parks the scan at slot 0, count 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= 2'd0;
        end else if (!en) begin
            r_cnt <= '0;
            r_idx <= 2'd0;
        end else if (w_slot_end) begin
            r_cnt <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Capture the whole pattern bus once per frame so no digit tears mid-scan
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow <= '1;
        end else if (en && w_frame_end) begin
            r_shadow <= digits;
        end
    end

    // Decode the current slot: dark while disabled, in the anti-ghosting gap, or blink-suppressed
    always_comb begin
        w_dark     = (!en) || (r_cnt < CNT_BLANK) || w_suppress;
        w_an_next  = 4'b1111;
        w_seg_next = 7'h7F;
        if (!w_dark) begin
            w_an_next  = ~(4'b0001 << r_idx);
            w_seg_next = r_shadow[r_idx];
        end
    end

    // Register the pins so anode and segment lines change together, glitch-free
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an  <= 4'b1111;
            r_seg <= 7'h7F;
        end else begin
            r_an  <= w_an_next;
            r_seg <= w_seg_next;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = 1'b1;

endmodule

// File: tb/tb_seg_display_scan.sv
// tb/tb_seg_display_scan.sv - scoreboard bench for seg_display_scan
`timescale 1ns/1ps
module tb_seg_display_scan;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int BF    = 2;
    localparam int FRAME = 4 * DIV;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            en = 1'b1;
    logic            blink = 1'b0;
    logic [3:0][6:0] digits = '0;
    logic [3:0]      an;
    logic [6:0]      seg;
    logic            dp;

    int n_checks = 0;
    int n_errors = 0;

    logic [10:0] exp_q[$];

    int              m_pos;
    logic [3:0][6:0] m_shadow;
    int              m_frames;
    logic            m_phase;

    seg_display_scan #(
        .DIV(DIV),
        .BLANK(BLANK),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .blink(blink),
        .digits(digits),
        .an(an),
        .seg(seg),
        .dp(dp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pos    = 0;
        m_shadow = '1;
        m_frames = 0;
        m_phase  = 1'b0;
    endtask

    // Expected {an,seg} just after the coming edge, from the timeline position before it
    function automatic logic [10:0] model_out();
        logic       dark;
        int         slot;
        logic [3:0] onehot;
        slot = m_pos / DIV;
        dark = rst || !en || ((m_pos % DIV) < BLANK);
`ifdef SEG_BLINK_EN
        if (blink && m_phase) dark = 1'b1;
`endif
        if (dark) return {4'hF, 7'h7F};
        onehot = 4'b0001 << slot;
        return {~onehot, m_shadow[slot]};
    endfunction

    task automatic model_advance();
        if (rst) begin
            model_reset();
        end else if (!en) begin
            m_pos    = 0;
            m_frames = 0;
            m_phase  = 1'b0;
        end else if (m_pos == FRAME - 1) begin
            m_pos    = 0;
            m_shadow = digits;
            if (m_frames == BF - 1) begin
                m_frames = 0;
                m_phase  = !m_phase;
            end else begin
                m_frames++;
            end
        end else begin
            m_pos++;
        end
    endtask

    // One clock: push the expectation, clock the DUT, pop and compare at the falling edge
    task automatic step(input string tag);
        logic [10:0] e;
        exp_q.push_back(model_out());
        model_advance();
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        check(tag, {an, seg}, e);
        check("dp", dp, 1);
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    task automatic run_to(input string tag, input int pos);
        int guard;
        guard = 0;
        while (m_pos != pos && guard < 2 * FRAME) begin
            step(tag);
            guard++;
        end
        check({tag, "_reach"}, m_pos, pos);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        rst = 1'b1;
        en  = 1'b1;

        // reset hold with random patterns
        for (int i = 0; i < 5; i++) begin
            digits = {7'($urandom), 7'($urandom), 7'($urandom), 7'($urandom)};
            step("reset_hold");
        end

        // release: first frame shows blank patterns, then the captured ones
        rst    = 1'b0;
        digits = {7'h30, 7'h24, 7'h79, 7'h40};
        run("first_frame", FRAME);
        run("scan", 2 * FRAME);

        // change digit 0 during slot 1; effective only from the next frame
        run_to("to_slot1", DIV + 3);
        digits[0] = 7'h12;
        run_to("to_slot2", 2 * DIV + 1);
        digits[2] = 7'h00;
        run_to("to_slot3", 3 * DIV + 1);
        digits[2] = 7'h24;
        run("latch", 2 * FRAME);

        // enable drop mid-slot 2
        run_to("to_en_drop", 2 * DIV + 3);
        en = 1'b0;
        run("en_low", 5);
        en = 1'b1;
        run("re_enable", 40);

        // blink request, then release
        blink = 1'b1;
        run("blink_on", 5 * FRAME);
        blink = 1'b0;
        run("blink_off", 2 * FRAME);

        // asynchronous reset pulse between edges
        run_to("to_mid", DIV + 4);
        #2;
        rst = 1'b1;
        #0.5;
        check("async_rst_an", an, 4'hF);
        check("async_rst_seg", seg, 7'h7F);
        #0.5;
        rst = 1'b0;
        model_reset();
        digits = {7'($urandom), 7'($urandom), 7'($urandom), 7'($urandom)};
        run("after_pulse", 2 * FRAME);

        // random mix of enable, blink and pattern changes
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 19) == 0) en = ~en;
            if ($urandom_range(0, 9) == 0) digits[$urandom_range(0, 3)] = 7'($urandom);
            if ($urandom_range(0, 49) == 0) blink = ~blink;
            step("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
